// File: rtl/apb_protocol_checker.sv
// Passive APB monitor: it flags six protocol rules (R0..R5) and counts completed transfers.
// It samples the bus on every pclk rising edge and never drives it.
module apb_protocol_checker #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic              clr,
    output logic [5:0]        err_sticky,
    output logic              err_pulse,
    output logic [2:0]        first_err,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  slverr_cnt,
    output logic [7:0]        max_wait,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [7:0]          r_wait, w_wait_nxt, w_wait_inc, w_done_wait;
    logic                r_r2_seen, w_r2_nxt;
    logic                w_capture, w_done, w_both, w_unstable;
    logic [5:0]          w_viol;
    logic [2:0]          w_first_idx;

    logic [5:0]          r_sticky, w_sticky_base;
    logic [2:0]          r_first, w_first_base;
    logic                r_pulse;
    logic [CNT_W-1:0]    r_wr, r_rd, r_slv, w_wr_base, w_rd_base, w_slv_base;
    logic [7:0]          r_max, w_max_base;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign w_both     = psel & penable;
    assign w_unstable = (paddr != r_addr) || (pwrite != r_write) ||
                        (r_write && (pwdata != r_wdata));
    assign w_wait_inc = (r_state == SETUP) ? 8'd1 : r_wait + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_r2_nxt    = r_r2_seen;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        w_done_wait = 8'd0;
        w_viol      = 6'd0;
        case (r_state)
            IDLE: begin
                if (!psel && penable) begin
                    w_viol[0] = 1'b1;
                end else if (w_both) begin
                    w_viol[5] = 1'b1;
                end else if (psel) begin
                    w_capture   = 1'b1;
                    w_r2_nxt    = 1'b0;
                    w_wait_nxt  = 8'd0;
                    w_state_nxt = SETUP;
                end
            end
            SETUP, ACCESS: begin
                if (w_both) begin
                    if (w_unstable && !r_r2_seen) begin
                        w_viol[2] = 1'b1;
                        w_r2_nxt  = 1'b1;
                    end
                    if (pready) begin
                        w_done      = 1'b1;
                        w_done_wait = (r_state == ACCESS) ? r_wait : 8'd0;
                        w_wait_nxt  = 8'd0;
                        w_state_nxt = IDLE;
                    end else if (w_wait_inc >= MAX_WAIT_L) begin
                        w_viol[4]   = 1'b1;
                        w_wait_nxt  = 8'd0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_wait_nxt  = w_wait_inc;
                        w_state_nxt = ACCESS;
                    end
                end else if (r_state == SETUP) begin
                    // Any SETUP sample other than psel&penable means no access phase followed.
                    w_viol[1] = 1'b1;
                    if (psel) begin
                        w_capture = 1'b1;
                        w_r2_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_viol[3]   = 1'b1;
                    w_wait_nxt  = 8'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_first_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (w_viol[i]) w_first_idx = 3'(i + 1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state   <= IDLE;
            r_wait    <= 8'd0;
            r_r2_seen <= 1'b0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_r2_seen <= w_r2_nxt;
            if (w_capture) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
            end
        end
    end

    // A clear lands first, so an event on the same edge survives it.
    assign w_sticky_base = clr ? 6'd0 : r_sticky;
    assign w_first_base  = clr ? 3'd0 : r_first;
    assign w_wr_base     = clr ? '0 : r_wr;
    assign w_rd_base     = clr ? '0 : r_rd;
    assign w_slv_base    = clr ? '0 : r_slv;
    assign w_max_base    = clr ? 8'd0 : r_max;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_sticky <= 6'd0;
            r_first  <= 3'd0;
            r_pulse  <= 1'b0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_slv    <= '0;
            r_max    <= 8'd0;
        end else begin
            r_sticky <= w_sticky_base | w_viol;
            r_first  <= (w_first_base == 3'd0) ? w_first_idx : w_first_base;
            r_pulse  <= |w_viol;
            r_wr     <= sat_inc(w_wr_base, w_done && r_write);
            r_rd     <= sat_inc(w_rd_base, w_done && !r_write);
            r_slv    <= sat_inc(w_slv_base, w_done && pslverr);
            r_max    <= (w_done && (w_done_wait > w_max_base)) ? w_done_wait : w_max_base;
        end
    end

    assign err_sticky  = r_sticky;
    assign err_pulse   = r_pulse;
    assign first_err   = r_first;
    assign wr_cnt      = r_wr;
    assign rd_cnt      = r_rd;
    assign slverr_cnt  = r_slv;
    assign max_wait    = r_max;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Randomized and directed bench for apb_protocol_checker, compared every cycle
// against a transfer-level reference model.
module tb_apb_protocol_checker;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int EW   = 6 + 1 + 3 + 3 * CW + 8;

  // clock / reset and bus signals
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic psel = 0, penable = 0, pwrite = 0, pready = 0, pslverr = 0, clr = 0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [5:0] err_sticky;
  logic err_pulse;
  logic [2:0] first_err;
  logic [CW-1:0] wr_cnt, rd_cnt, slverr_cnt;
  logic [7:0] max_wait;
  logic [1:0] dbg_state;

  always #5 pclk = ~pclk;

  apb_protocol_checker #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pready(pready), .pslverr(pslverr), .paddr(paddr), .pwdata(pwdata), .clr(clr),
    .err_sticky(err_sticky), .err_pulse(err_pulse), .first_err(first_err),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .slverr_cnt(slverr_cnt), .max_wait(max_wait),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: transfer-level view of the rules
  bit m_open, m_access, m_r2, m_w;
  int m_waits;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  bit [5:0] m_sticky;
  bit m_pulse;
  int m_first, m_wr, m_rd, m_slv, m_max;
  logic [EW-1:0] exp_q[$];

  function automatic int sat(input int v);
    return (v + 1 > CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_open = 0; m_access = 0; m_r2 = 0; m_waits = 0;
    m_sticky = 0; m_pulse = 0; m_first = 0; m_wr = 0; m_rd = 0; m_slv = 0; m_max = 0;
  endtask

  task automatic model_step();
    bit [5:0] v;
    bit done, dwr, unst, found;
    int dw;
    v = 0; done = 0; dwr = 0; dw = 0; found = 0;
    unst = (paddr != m_a) || (pwrite != m_w) || (m_w && (pwdata != m_d));
    if (!m_open) begin
      if (penable && !psel) v[0] = 1;
      else if (psel && penable) v[5] = 1;
      else if (psel) begin
        m_open = 1; m_access = 0; m_r2 = 0; m_a = paddr; m_w = pwrite; m_d = pwdata;
      end
    end else if (psel && penable) begin
      if (unst && !m_r2) begin v[2] = 1; m_r2 = 1; end
      if (pready) begin
        done = 1; dwr = m_w; dw = m_access ? m_waits : 0; m_open = 0;
      end else begin
        m_waits = m_access ? m_waits + 1 : 1;
        m_access = 1;
        if (m_waits >= MW) begin v[4] = 1; m_open = 0; end
      end
    end else if (!m_access) begin
      v[1] = 1;
      if (psel) begin m_a = paddr; m_w = pwrite; m_d = pwdata; m_r2 = 0; end
      else m_open = 0;
    end else begin
      v[3] = 1; m_open = 0;
    end
    if (clr) begin
      m_sticky = 0; m_first = 0; m_wr = 0; m_rd = 0; m_slv = 0; m_max = 0;
    end
    m_sticky |= v;
    if (m_first == 0) begin
      for (int i = 0; i < 6; i++) begin
        if (v[i] && !found) begin m_first = i + 1; found = 1; end
      end
    end
    m_pulse = (v != 0);
    if (done) begin
      if (dwr) m_wr = sat(m_wr); else m_rd = sat(m_rd);
      if (pslverr) m_slv = sat(m_slv);
      if (dw > m_max) m_max = dw;
    end
  endtask

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
    end
    exp_q.push_back({m_sticky, m_pulse, 3'(m_first), CW'(m_wr), CW'(m_rd), CW'(m_slv), 8'(m_max)});
  end

  // scoreboard: one compare per output field every cycle
  always @(negedge pclk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("err_sticky", err_sticky, e[EW-1 -: 6]);
      check("err_pulse", err_pulse, e[EW-7]);
      check("first_err", first_err, e[EW-8 -: 3]);
      check("wr_cnt", wr_cnt, e[8+3*CW-1 -: CW]);
      check("rd_cnt", rd_cnt, e[8+2*CW-1 -: CW]);
      check("slverr_cnt", slverr_cnt, e[8+CW-1 -: CW]);
      check("max_wait", max_wait, e[7:0]);
    end
  end

  // driver tasks: set inputs, then let one rising edge sample them
  task automatic cyc(input bit s, input bit e, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit r, input bit er, input bit c);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d; pready = r; pslverr = er; clr = c;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input bit c);
    cyc(0, 0, 0, '0, '0, 0, 0, c);
  endtask

  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input bit er);
    cyc(1, 0, w, a, d, 0, 0, 0);
    for (int i = 0; i < waits; i++) cyc(1, 1, w, a, d, 0, 0, 0);
    cyc(1, 1, w, a, d, 1, er, 0);
    idle(0);
  endtask

  task automatic do_reset();
    presetn = 0;
    idle(0);
    idle(0);
    presetn = 1;
  endtask

  task automatic rxfer();
    bit w, er, c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int waits, drop;
    w = 1'($urandom_range(0, 1));
    a = AW'($urandom_range(0, 3) * 4 + 'h10);
    d = DW'($urandom);
    waits = $urandom_range(0, 5);
    drop = $urandom_range(0, 9);
    cyc(1, 0, w, a, d, 0, 0, 0);
    for (int i = 0; i < waits; i++) begin
      if ($urandom_range(0, 7) == 0) a = a ^ AW'(4);
      if ($urandom_range(0, 7) == 0) d = d + DW'(1);
      c = ($urandom_range(0, 19) == 0);
      if (drop == 0 && i == waits - 1) cyc(0, 0, w, a, d, 0, 0, c);
      else cyc(1, 1, w, a, d, 0, 0, c);
    end
    er = 1'($urandom_range(0, 1));
    c = ($urandom_range(0, 9) == 0);
    cyc(1, 1, w, a, d, 1, er, c);
    if ($urandom_range(0, 1) == 1) idle(0);
  endtask

  initial begin
    do_reset();
    check("reset sticky", err_sticky, 6'd0);
    check("reset wr_cnt", wr_cnt, 0);
    check("reset first", first_err, 3'd0);

    // write 0 waits then read 2 waits
    xfer(1, 'h10, 'hA5A5, 0, 0);
    xfer(0, 'h10, '0, 2, 0);
    check("basic wr_cnt", wr_cnt, 1);
    check("basic rd_cnt", rd_cnt, 1);
    check("basic max_wait", max_wait, 2);
    check("basic sticky", err_sticky, 6'd0);

    // penable without psel
    idle(1);
    cyc(0, 1, 0, '0, '0, 0, 0, 0);
    check("r0 sticky", err_sticky, 6'b000001);
    check("r0 first", first_err, 3'd1);
    check("r0 pulse high", err_pulse, 1'b1);
    idle(0);
    check("r0 pulse low", err_pulse, 1'b0);

    // address change during a wait state
    idle(1);
    cyc(1, 0, 1, 'h10, 'h1234, 0, 0, 0);
    cyc(1, 1, 1, 'h10, 'h1234, 0, 0, 0);
    cyc(1, 1, 1, 'h14, 'h1234, 0, 0, 0);
    cyc(1, 1, 1, 'h14, 'h1234, 1, 0, 0);
    check("r2 sticky", err_sticky, 6'b000100);
    check("r2 wr_cnt", wr_cnt, 1);
    idle(0);

    // clear on the same edge as a completing read with slave error
    cyc(1, 0, 0, 'h30, '0, 0, 0, 0);
    cyc(1, 1, 0, 'h30, '0, 1, 1, 1);
    check("clr rd_cnt", rd_cnt, 1);
    check("clr slverr", slverr_cnt, 1);
    check("clr wr_cnt", wr_cnt, 0);
    check("clr sticky", err_sticky, 6'd0);
    check("clr first", first_err, 3'd0);
    check("clr max_wait", max_wait, 0);
    idle(0);

    // timeout after MAX_WAIT waits, then a stray pready
    idle(1);
    cyc(1, 0, 0, 'h20, '0, 0, 0, 0);
    for (int i = 0; i < MW; i++) cyc(1, 1, 0, 'h20, '0, 0, 0, 0);
    check("r4 sticky", err_sticky, 6'b010000);
    cyc(1, 1, 0, 'h20, '0, 1, 0, 0);
    check("r4r5 sticky", err_sticky, 6'b110000);
    check("r4r5 first", first_err, 3'd5);
    check("r4 rd_cnt", rd_cnt, 0);
    idle(0);

    // setup without access, then access dropped
    idle(1);
    cyc(1, 0, 1, 'h40, 'h1, 0, 0, 0);
    idle(0);
    cyc(1, 0, 1, 'h40, 'h1, 0, 0, 0);
    cyc(1, 1, 1, 'h40, 'h1, 0, 0, 0);
    idle(0);
    check("r1r3 sticky", err_sticky, 6'b001010);
    check("r1r3 first", first_err, 3'd2);

    // saturation
    idle(1);
    for (int i = 0; i < CMAX + 2; i++) xfer(1, 'h50, DW'(i), 0, 0);
    check("sat wr_cnt", wr_cnt, CMAX);

    // reset mid-access, then a clean write
    cyc(1, 0, 1, 'h60, 'h77, 0, 0, 0);
    cyc(1, 1, 1, 'h60, 'h77, 0, 0, 0);
    presetn = 0;
    #1;
    check("async reset wr_cnt", wr_cnt, 0);
    idle(0);
    presetn = 1;
    xfer(1, 'h60, 'h77, 0, 0);
    check("post-reset sticky", err_sticky, 6'd0);
    check("post-reset wr_cnt", wr_cnt, 1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 19))
        0, 1: cyc(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom_range(0, 1) * 4 + 'h10),
                  DW'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0));
        2: idle(1'($urandom_range(0, 1)));
        3: if ($urandom_range(0, 9) == 0) do_reset(); else idle(0);
        default: rxfer();
      endcase
    end
    idle(0);
    idle(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
